// File: rtl/wishbone_bridge.sv
// wishbone_bridge: stalls a single-cycle cpu while one Wishbone B4 classic cycle completes
module wishbone_bridge #(
  parameter int          TIMEOUT_CYCLES   = 16,
  parameter logic [31:0] READ_ERROR_VALUE = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read_request,
  input  logic        cpu_write_enable,
  input  logic [3:0]  cpu_byte_enable,
  input  logic [31:0] cpu_write_data,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic        bus_error,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  input  logic        wb_err
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t state, next_state;
  logic [CW-1:0] count;
  logic request, timeout;
  assign request   = cpu_read_request | cpu_write_enable;
  assign timeout   = count == CW'(TIMEOUT_CYCLES - 1);
  assign cpu_stall = (state == IDLE && request) || state == BUS;
  // state register; async reset returns to IDLE immediately
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next_state;
  // DONE always lasts one cycle so the held request is never re-issued
  always_comb begin
    next_state = state;
    next_state = state == IDLE ? (request ? BUS : IDLE)
               : state == BUS  ? ((wb_err || wb_ack || timeout) ? DONE : BUS)
               : IDLE;
  end
  // bus signals, captured request, timeout counter and cpu-facing results
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wb_cyc        <= 1'b0;
      wb_stb        <= 1'b0;
      wb_we         <= 1'b0;
      wb_adr        <= '0;
      wb_sel        <= '0;
      wb_dat_o      <= '0;
      cpu_read_data <= '0;
      bus_error     <= 1'b0;
      count         <= '0;
    end else begin
      wb_cyc <= next_state == BUS;
      wb_stb <= next_state == BUS;
      if (state == IDLE && request) begin
        wb_adr   <= {cpu_address[31:2], 2'b00};
        wb_sel   <= cpu_byte_enable;
        wb_dat_o <= cpu_write_data;
        wb_we    <= cpu_write_enable;
        count    <= '0;
      end
      if (state == BUS) begin
        count <= count + CW'(1);
        if (wb_err || (!wb_ack && timeout)) begin
          bus_error <= 1'b1;
          if (!wb_we) cpu_read_data <= READ_ERROR_VALUE;
        end else if (wb_ack && !wb_we) cpu_read_data <= wb_dat_i;
      end
    end
endmodule

// File: tb/tb_wishbone_bridge.sv
// tb_wishbone_bridge: directed checks of the cpu-to-Wishbone bridge
module tb_wishbone_bridge;
  logic        clock = 1'b0, reset = 1'b0;
  logic [31:0] cpu_address = '0, cpu_write_data = '0, wb_dat_i = '0;
  logic        cpu_read_request = 1'b0, cpu_write_enable = 1'b0;
  logic [3:0]  cpu_byte_enable = '0;
  logic [31:0] cpu_read_data, wb_adr, wb_dat_o;
  logic        cpu_stall, bus_error, wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic        wb_ack = 1'b0, wb_err = 1'b0;
  int checks = 0, failures = 0, rises = 0, stalls, cycs, r0;
  logic [31:0] cap_adr, cap_dat;
  logic [3:0]  cap_sel;
  logic        cap_we;

  wishbone_bridge dut (
    .clock(clock), .reset(reset), .cpu_address(cpu_address),
    .cpu_read_request(cpu_read_request), .cpu_write_enable(cpu_write_enable),
    .cpu_byte_enable(cpu_byte_enable), .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data), .cpu_stall(cpu_stall), .bus_error(bus_error),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_sel(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_err(wb_err)
  );

  always #5 clock = ~clock;
  always @(posedge wb_cyc) rises++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // drive one cpu access; slave answers on BUS cycle ack_at/err_at (0 = never); returns in DONE
  task automatic access(input logic re, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] wdat, input logic [31:0] rdat, input int ack_at, input int err_at);
    int bus_n;
    bit done;
    cpu_read_request = re;
    cpu_write_enable = we;
    cpu_address = adr;
    cpu_byte_enable = sel;
    cpu_write_data = wdat;
    wb_dat_i = rdat;
    stalls = 0;
    cycs = 0;
    bus_n = 0;
    done = 0;
    #1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (!cpu_stall) done = 1;
      else begin
        stalls++;
        if (wb_cyc) begin
          bus_n++;
          cycs++;
          if (bus_n == 1) begin
            cap_adr = wb_adr;
            cap_sel = wb_sel;
            cap_dat = wb_dat_o;
            cap_we = wb_we;
          end
        end
        wb_ack = bus_n == ack_at;
        wb_err = bus_n == err_at;
        tick();
        wb_ack = 1'b0;
        wb_err = 1'b0;
      end
    end
    if (!done) check("access_bound", 32'd1, 32'd0);
  endtask

  task automatic idle_cpu;
    cpu_read_request = 1'b0;
    cpu_write_enable = 1'b0;
    tick();
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #2;
    check("rst_cyc", wb_cyc, 0);
    check("rst_adr", wb_adr, 0);
    check("rst_data", cpu_read_data, 0);
    check("rst_err", bus_error, 0);
    tick();
    reset = 1'b1;
    tick();
    check("idle_stall", cpu_stall, 0);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    check("stray_ack_cyc", wb_cyc, 0);

    access(1, 0, 32'h0000_0104, 4'hF, 0, 32'hCAFE_F00D, 2, 0);
    check("rd_adr", cap_adr, 32'h104);
    check("rd_we", cap_we, 0);
    check("rd_stalls", stalls, 3);
    check("rd_data", cpu_read_data, 32'hCAFE_F00D);
    check("rd_done_cyc", wb_cyc, 0);
    check("rd_err", bus_error, 0);
    idle_cpu();

    access(0, 1, 32'h0000_0203, 4'b1000, 32'h1234_5678, 32'h0BAD_0BAD, 1, 0);
    check("wr_adr", cap_adr, 32'h200);
    check("wr_sel", cap_sel, 4'h8);
    check("wr_dat", cap_dat, 32'h1234_5678);
    check("wr_we", cap_we, 1);
    check("wr_stalls", stalls, 2);
    check("wr_rdata_kept", cpu_read_data, 32'hCAFE_F00D);
    idle_cpu();

    access(1, 0, 32'h0000_0040, 4'hF, 0, 32'hFFFF_FFFF, 0, 0);
    check("to_cycs", cycs, 16);
    check("to_data", cpu_read_data, 0);
    check("to_err", bus_error, 1);
    idle_cpu();
    repeat (5) tick();
    check("to_err_sticky", bus_error, 1);

    do_reset();
    check("rst2_err", bus_error, 0);
    access(1, 0, 32'h0000_0008, 4'hF, 0, 32'h5555_AAAA, 1, 0);
    check("pre_data", cpu_read_data, 32'h5555_AAAA);
    idle_cpu();
    access(1, 0, 32'h0000_000C, 4'hF, 0, 32'hDEAD_BEEF, 1, 1);
    check("errack_data", cpu_read_data, 0);
    check("errack_err", bus_error, 1);
    idle_cpu();

    do_reset();
    cpu_read_request = 1'b1;
    cpu_address = 32'h0000_0300;
    tick();
    check("mid_cyc_before", wb_cyc, 1);
    #2;
    reset = 1'b0;
    cpu_read_request = 1'b0;
    #1;
    check("mid_cyc_async", wb_cyc, 0);
    check("mid_stb_async", wb_stb, 0);
    tick();
    #2;
    reset = 1'b1;
    tick();
    wb_ack = 1'b1;
    wb_dat_i = 32'h7777_7777;
    tick();
    wb_ack = 1'b0;
    check("late_ack_stall", cpu_stall, 0);
    check("late_ack_cyc", wb_cyc, 0);
    check("late_ack_adr", wb_adr, 0);
    check("late_ack_data", cpu_read_data, 0);

    r0 = rises;
    access(1, 1, 32'h0000_0010, 4'hF, 32'h0000_00AA, 32'h0000_0011, 1, 0);
    check("both_we", cap_we, 1);
    cpu_write_enable = 1'b0;
    tick();
    check("gap1_cyc", wb_cyc, 0);
    check("gap1_stall", cpu_stall, 1);
    access(1, 0, 32'h0000_0014, 4'hF, 0, 32'h0000_0022, 1, 0);
    check("b2b1_we", cap_we, 0);
    check("b2b1_data", cpu_read_data, 32'h22);
    tick();
    check("gap2_cyc", wb_cyc, 0);
    access(1, 0, 32'h0000_0018, 4'hF, 0, 32'h0000_0033, 1, 0);
    check("b2b2_data", cpu_read_data, 32'h33);
    idle_cpu();
    tick();
    check("b2b_rises", rises - r0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
